// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder
// and the decoder that consumes its words.
package riscv_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_JALR    = 3'b000;
  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_BAD_OP = 2'b01,
    ERR_IMM    = 2'b10,
    ERR_OVF    = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FULL = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_fields_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Session control, field-bundle handshake and instruction-memory write port.
interface inst_encoder_if
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  err_code_e         err_code;
  logic [ADDR_W:0]   count;

  modport master (
    output start, base_addr, in_valid, in_last, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code,
           count
  );

  modport slave (
    input  start, base_addr, in_valid, in_last, in_opcode, in_rd, in_rs1,
           in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code,
           count
  );

endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packer with opcode and immediate-range checks.
module inst_pack
  import riscv_pkg::*;
(
  input  inst_fields_t i_fields,
  output logic [31:0]  o_word,
  output logic         o_bad_op,
  output logic         o_bad_imm
);

  always_comb begin
    o_word    = NOP_WORD;
    o_bad_op  = 1'b0;
    o_bad_imm = 1'b0;
    case (i_fields.opcode)
      OPC_R: begin
        o_word = {i_fields.funct7, i_fields.rs2, i_fields.rs1, i_fields.funct3,
                  i_fields.rd, i_fields.opcode};
      end
      OPC_I: begin
        o_word    = {i_fields.imm[11:0], i_fields.rs1, i_fields.funct3,
                     i_fields.rd, i_fields.opcode};
        o_bad_imm = (i_fields.imm[31:11] != {21{i_fields.imm[11]}});
      end
      OPC_JALR: begin
        o_word    = {i_fields.imm[11:0], i_fields.rs1, FUNCT3_JALR,
                     i_fields.rd, i_fields.opcode};
        o_bad_imm = (i_fields.imm[31:11] != {21{i_fields.imm[11]}});
      end
      OPC_LUI: begin
        o_word    = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
        o_bad_imm = |i_fields.imm[11:0];
      end
      OPC_JAL: begin
        o_word    = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                     i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
        // Jump offsets are halfword aligned; bit 0 cannot be encoded.
        o_bad_imm = (i_fields.imm[31:20] != {12{i_fields.imm[20]}}) |
                    i_fields.imm[0];
      end
      default: begin
        o_bad_op = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: packs accepted field bundles into consecutive
// instruction-memory words and tracks session status.
module inst_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
)(
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus
);

  localparam int unsigned     CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  err_code_e         r_err_code;
  logic [CNT_W-1:0]  r_count;

  inst_fields_t      w_fields;
  logic [31:0]       w_word;
  logic              w_bad_op;
  logic              w_bad_imm;
  logic              w_fire;
  logic [CNT_W-1:0]  w_count_inc;

  assign w_fields = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1,
                      rs2: bus.in_rs2, funct3: bus.in_funct3,
                      funct7: bus.in_funct7, imm: bus.in_imm};

  inst_pack u_pack (
    .i_fields  (w_fields),
    .o_word    (w_word),
    .o_bad_op  (w_bad_op),
    .o_bad_imm (w_bad_imm)
  );

  // r_ready is only set in RUN, so a handshake implies RUN.
  assign w_fire      = bus.in_valid & r_ready;
  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_count     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_RUN;
            r_addr     <= bus.base_addr;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= w_word;
            r_addr      <= r_addr + ADDR_W'(1);
            r_count     <= w_count_inc;
            if ((r_err_code == ERR_NONE) && (w_bad_op || w_bad_imm)) begin
              r_err      <= 1'b1;
              r_err_code <= w_bad_op ? ERR_BAD_OP : ERR_IMM;
            end
            // Overflow is bounded by words written, not by address wrap.
            if (bus.in_last) begin
              r_state <= ST_DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
            end else if (w_count_inc == DEPTH) begin
              r_state <= ST_FULL;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (r_err_code == ERR_NONE) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_OVF;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a 1K-word instance for encoding/session
// behaviour and a 4-word instance for the overflow path.
module tb_inst_encoder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inst_encoder_if #(.ADDR_W(10)) bus_a ();
  inst_encoder_if #(.ADDR_W(2))  bus_b ();

  inst_encoder #(.ADDR_W(10)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  inst_encoder #(.ADDR_W(2))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_a(input logic [9:0] base);
    @(negedge clk);
    bus_a.start     = 1'b1;
    bus_a.base_addr = base;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("start.busy", 64'(bus_a.busy), 64'd1);
    check("start.ready", 64'(bus_a.in_ready), 64'd1);
    check("start.count", 64'(bus_a.count), 64'd0);
    check("start.err", 64'(bus_a.err), 64'd0);
  endtask

  task automatic send_a(input string name, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input logic [9:0] exp_addr);
    int n;
    bus_a.in_opcode = op;
    bus_a.in_rd     = rd;
    bus_a.in_rs1    = rs1;
    bus_a.in_rs2    = rs2;
    bus_a.in_funct3 = f3;
    bus_a.in_funct7 = f7;
    bus_a.in_imm    = imm;
    bus_a.in_last   = last;
    bus_a.in_valid  = 1'b1;
    n = 0;
    while (!bus_a.in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, ".ready"}, 64'(bus_a.in_ready), 64'd1);
    @(posedge clk);
    #1;
    check({name, ".we"}, 64'(bus_a.mem_we), 64'd1);
    check({name, ".addr"}, 64'(bus_a.mem_addr), 64'(exp_addr));
    check({name, ".data"}, 64'(bus_a.mem_wdata), 64'(exp_word));
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic finish_a(input string name, input int exp_count, input logic exp_err,
                          input logic [1:0] exp_code);
    @(posedge clk);
    #1;
    check({name, ".done"}, 64'(bus_a.done), 64'd1);
    check({name, ".we_off"}, 64'(bus_a.mem_we), 64'd0);
    check({name, ".busy"}, 64'(bus_a.busy), 64'd0);
    check({name, ".count"}, 64'(bus_a.count), 64'(exp_count));
    check({name, ".err"}, 64'(bus_a.err), 64'(exp_err));
    check({name, ".code"}, 64'(bus_a.err_code), 64'(exp_code));
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, 64'(bus_a.done), 64'd0);
    check({name, ".code_hold"}, 64'(bus_a.err_code), 64'(exp_code));
  endtask

  task automatic check_reset_a(input string name);
    check({name, ".ready"}, 64'(bus_a.in_ready), 64'd0);
    check({name, ".we"}, 64'(bus_a.mem_we), 64'd0);
    check({name, ".addr"}, 64'(bus_a.mem_addr), 64'd0);
    check({name, ".data"}, 64'(bus_a.mem_wdata), 64'd0);
    check({name, ".busy"}, 64'(bus_a.busy), 64'd0);
    check({name, ".done"}, 64'(bus_a.done), 64'd0);
    check({name, ".err"}, 64'(bus_a.err), 64'd0);
    check({name, ".code"}, 64'(bus_a.err_code), 64'd0);
    check({name, ".count"}, 64'(bus_a.count), 64'd0);
  endtask

  logic [1:0]  exp_addr_b [4];
  logic [31:0] exp_data_b [4];

  initial begin
    int  k;
    logic done_seen;

    bus_a.start = 1'b0; bus_a.base_addr = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_a.in_opcode = '0; bus_a.in_rd = '0; bus_a.in_rs1 = '0; bus_a.in_rs2 = '0;
    bus_a.in_funct3 = '0; bus_a.in_funct7 = '0; bus_a.in_imm = '0;
    bus_b.start = 1'b0; bus_b.base_addr = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_b.in_opcode = '0; bus_b.in_rd = '0; bus_b.in_rs1 = '0; bus_b.in_rs2 = '0;
    bus_b.in_funct3 = '0; bus_b.in_funct7 = '0; bus_b.in_imm = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_a("rst");
    rst = 1'b0;

    // addi x1,x0,5
    start_a(10'h010);
    send_a("addi", OPC_I, 5'd1, 5'd0, 5'd0, FUNCT3_ADD_SUB, FUNCT7_BASE, 32'd5, 1'b1,
           32'h0050_0093, 10'h010);
    finish_a("s1", 1, 1'b0, 2'b00);

    // sub then lui, back-to-back, across the address wrap
    start_a(10'h3FF);
    send_a("sub", OPC_R, 5'd3, 5'd1, 5'd2, FUNCT3_ADD_SUB, FUNCT7_ALT, 32'd0, 1'b0,
           32'h4020_81B3, 10'h3FF);
    send_a("lui", OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1,
           32'h1234_52B7, 10'h000);
    finish_a("s2", 2, 1'b0, 2'b00);

    // jalr with funct3 forced, jal +8, jal +3 (misaligned)
    start_a(10'h040);
    send_a("jalr", OPC_JALR, 5'd1, 5'd2, 5'd31, 3'b101, 7'h7F, 32'hFFFF_FFFC, 1'b0,
           32'hFFC1_00E7, 10'h040);
    send_a("jal8", OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0,
           32'h0080_00EF, 10'h041);
    check("jal8.err", 64'(bus_a.err), 64'd0);
    send_a("jal3", OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1,
           32'h0020_00EF, 10'h042);
    finish_a("s3", 3, 1'b1, 2'b10);

    // bad opcode, then a bad immediate that must not override it
    start_a(10'h080);
    send_a("load", 7'b0000011, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 1'b0,
           NOP_WORD, 10'h080);
    check("load.code", 64'(bus_a.err_code), 64'd1);
    send_a("jal3b", OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1,
           32'h0020_00EF, 10'h081);
    finish_a("s4", 2, 1'b1, 2'b01);

    // I-type immediate just out of range, then a LUI with low bits set
    start_a(10'h0C0);
    send_a("addi2048", OPC_I, 5'd1, 5'd0, 5'd0, FUNCT3_ADD_SUB, FUNCT7_BASE, 32'h0000_0800,
           1'b0, 32'h8000_0093, 10'h0C0);
    check("addi2048.code", 64'(bus_a.err_code), 64'd2);
    send_a("luibad", OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b1,
           32'h1234_52B7, 10'h0C1);
    finish_a("s5", 2, 1'b1, 2'b10);

    // Overflow on the 4-word instance
    exp_addr_b = '{2'd3, 2'd0, 2'd1, 2'd2};
    exp_data_b = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213};
    @(negedge clk);
    bus_b.start     = 1'b1;
    bus_b.base_addr = 2'd3;
    @(negedge clk);
    bus_b.start     = 1'b0;
    bus_b.in_opcode = OPC_I;
    bus_b.in_funct3 = FUNCT3_ADD_SUB;
    bus_b.in_valid  = 1'b1;
    k = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus_b.in_rd  = 5'(k + 1);
      bus_b.in_imm = 32'(k);
      @(posedge clk);
      #1;
      if (bus_b.mem_we) begin
        if (k < 4) begin
          check("ovf.addr", 64'(bus_b.mem_addr), 64'(exp_addr_b[k]));
          check("ovf.data", 64'(bus_b.mem_wdata), 64'(exp_data_b[k]));
        end
        k++;
        if (k == 4) check("ovf.ready_drop", 64'(bus_b.in_ready), 64'd0);
      end
      if (bus_b.done) done_seen = 1'b1;
    end
    bus_b.in_valid = 1'b0;
    check("ovf.writes", 64'(k), 64'd4);
    check("ovf.done", 64'(done_seen), 64'd1);
    check("ovf.err", 64'(bus_b.err), 64'd1);
    check("ovf.code", 64'(bus_b.err_code), 64'd3);
    check("ovf.count", 64'(bus_b.count), 64'd4);
    check("ovf.busy", 64'(bus_b.busy), 64'd0);

    // Reset asserted on a handshake cycle drops the write
    start_a(10'h100);
    bus_a.in_opcode = OPC_I; bus_a.in_rd = 5'd1; bus_a.in_rs1 = 5'd0;
    bus_a.in_funct3 = FUNCT3_ADD_SUB; bus_a.in_imm = 32'd5; bus_a.in_last = 1'b1;
    bus_a.in_valid  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    start_a(10'h020);
    send_a("addi_r", OPC_I, 5'd1, 5'd0, 5'd0, FUNCT3_ADD_SUB, FUNCT7_BASE, 32'd5, 1'b1,
           32'h0050_0093, 10'h020);
    finish_a("s7", 1, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
